// File: rtl/count_pkg.sv
// Shared counter definitions: the FSM state encoding and the default counter width
// used by both the up- and down-counting timers.
package count_pkg;

  localparam int COUNT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } count_state_t;

endpackage

// File: rtl/count8down_fsm.sv
// Loadable down-counting timer with a one-cycle expiry pulse.
// Define COUNT8DOWN_AUTO_RELOAD_EN to reload from RLD on expiry for a periodic tick.
import count_pkg::*;

module count8down_fsm #(
  parameter int WIDTH = COUNT_WIDTH
) (
  input  logic             clk,
  input  logic             res,
  input  logic             clr,
  input  logic             load,
  input  logic             EN,
  input  logic [WIDTH-1:0] CNT_In,
  output logic [WIDTH-1:0] CNT,
  output logic             BUSY,
  output logic             ZERO,
  output logic             DONE_P
);

  count_state_t     state_reg, state_next;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] rld_reg, rld_next;
  logic             done_p_reg, done_p_next;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    rld_next    = rld_reg;
    done_p_next = 1'b0;

    if (clr) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else if (load) begin
      // A load overrides everything below it, including a pending expiry pulse.
      rld_next   = CNT_In;
      cnt_next   = CNT_In;
      state_next = (CNT_In != '0) ? RUN : IDLE;
    end else begin
      case (state_reg)
        RUN: begin
          if (EN) begin
            if (cnt_reg == WIDTH'(1)) begin
              done_p_next = 1'b1;
`ifdef COUNT8DOWN_AUTO_RELOAD_EN
              cnt_next   = rld_reg;
              state_next = RUN;
`else
              cnt_next   = '0;
              state_next = DONE;
`endif
            end else begin
              cnt_next = cnt_reg - WIDTH'(1);
            end
          end
        end
        DONE:    cnt_next = '0;
        IDLE:    cnt_next = cnt_reg;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      rld_reg    <= '0;
      done_p_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      rld_reg    <= rld_next;
      done_p_reg <= done_p_next;
    end
  end

  assign CNT    = cnt_reg;
  assign BUSY   = (state_reg == RUN);
  assign ZERO   = (cnt_reg == '0);
  assign DONE_P = done_p_reg;

endmodule

// File: tb/tb_count8down_fsm.sv
// Self-checking bench for count8down_fsm: directed scenarios plus random traffic
// checked against a cycle-level reference model of the timer rules.
module tb_count8down_fsm;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic       EN = 1'b0;
  logic [7:0] CNT_In = 8'h00;
  logic [7:0] CNT;
  logic       BUSY, ZERO, DONE_P;

  int tests = 0;
  int fails = 0;

  // reference model state
  int m_cnt   = 0;
  int m_rld   = 0;
  bit m_run   = 0;
  bit m_pulse = 0;

`ifdef COUNT8DOWN_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  count8down_fsm #(.WIDTH(8)) dut (
    .clk(clk), .res(res), .clr(clr), .load(load), .EN(EN), .CNT_In(CNT_In),
    .CNT(CNT), .BUSY(BUSY), .ZERO(ZERO), .DONE_P(DONE_P)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_rld = 0; m_run = 0; m_pulse = 0;
  endtask

  // One clock of the timer rules: clr beats load beats counting.
  task automatic model_step(input bit c, input bit l, input bit e, input int d);
    m_pulse = 0;
    if (c) begin
      m_cnt = 0; m_run = 0;
    end else if (l) begin
      m_rld = d; m_cnt = d; m_run = (d != 0);
    end else if (m_run && e) begin
      if (m_cnt == 1) begin
        m_pulse = 1;
        m_cnt   = AUTO ? m_rld : 0;
        m_run   = AUTO;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".CNT"},    CNT,           8'(m_cnt));
    chk({tag, ".BUSY"},   8'(BUSY),      8'(m_run));
    chk({tag, ".ZERO"},   8'(ZERO),      8'(m_cnt == 0));
    chk({tag, ".DONE_P"}, 8'(DONE_P),    8'(m_pulse));
  endtask

  // Drive one cycle, advance through the rising edge, then compare 1 time unit later.
  task automatic cyc(input bit c, input bit l, input bit e, input logic [7:0] d, input string tag);
    clr = c; load = l; EN = e; CNT_In = d;
    @(posedge clk);
    model_step(c, l, e, int'(d));
    #1;
    check_all(tag);
    $display("[TB] %s clr=%0b load=%0b en=%0b in=%02h -> cnt=%02h busy=%0b zero=%0b done_p=%0b",
             tag, c, l, e, d, CNT, BUSY, ZERO, DONE_P);
  endtask

  int pulse_at;

  initial begin
    // reset state
    #2;
    check_all("reset");
    @(negedge clk); res = 1'b1;

    // async reset mid-RUN with CNT=5
    cyc(0, 1, 0, 8'h05, "ld5");
    cyc(0, 0, 0, 8'h00, "hold5");
    @(negedge clk); #2; res = 1'b0; #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst.cnt_const", CNT, 8'h00);
    @(negedge clk); res = 1'b1;
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 8'h00, "post_rst");

    // one-shot: load 3, EN continuous
    cyc(0, 1, 0, 8'h03, "os_ld");
    chk("os_ld.cnt3", CNT, 8'h03);
    pulse_at = 0;
    for (int i = 1; i <= 13; i++) begin
      cyc(0, 0, 1, 8'h00, "os_run");
      if (DONE_P === 1'b1 && pulse_at == 0) pulse_at = i;
    end
    chk("os_pulse_cycle", 8'(pulse_at), 8'd3);

    // EN gaps: load 4, EN 1,0,0,1,1,1 -> pulse after 6 cycles
    cyc(0, 1, 0, 8'h04, "gap_ld");
    pulse_at = 0;
    for (int i = 1; i <= 6; i++) begin
      cyc(0, 0, (i != 2 && i != 3), 8'h00, "gap_run");
      if (DONE_P === 1'b1 && pulse_at == 0) pulse_at = i;
    end
    chk("gap_pulse_cycle", 8'(pulse_at), 8'd6);

    // load and EN together: no decrement
    cyc(0, 1, 1, 8'h07, "ld_en");
    chk("ld_en.cnt7", CNT, 8'h07);

    // clr and load together
    cyc(1, 1, 1, 8'h09, "clr_ld");
    chk("clr_ld.cnt0", CNT, 8'h00);

    // load 0 -> IDLE, no pulse
    cyc(0, 1, 1, 8'h00, "ld0");
    cyc(0, 0, 1, 8'h00, "ld0_idle");

    // load on the expiry cycle cancels the pulse
    cyc(0, 1, 0, 8'h02, "exp_ld");
    cyc(0, 0, 1, 8'h00, "exp_run");
    cyc(0, 1, 1, 8'h06, "exp_reld");
    chk("exp_reld.nopulse", 8'(DONE_P), 8'h00);
    chk("exp_reld.cnt6", CNT, 8'h06);

    // width boundary: 0xFF takes 255 enabled cycles
    cyc(0, 1, 0, 8'hFF, "ff_ld");
    pulse_at = 0;
    for (int i = 1; i <= 258; i++) begin
      clr = 0; load = 0; EN = 1; CNT_In = 8'h00;
      @(posedge clk);
      model_step(0, 0, 1, 0);
      #1;
      check_all("ff_run");
      if (DONE_P === 1'b1 && pulse_at == 0) pulse_at = i;
    end
    $display("[TB] ff_run first pulse at cycle %0d cnt=%02h", pulse_at, CNT);
    chk("ff_pulse_cycle", 8'(pulse_at), 8'd255);

    // auto-reload pattern (or one-shot equivalent without the macro)
    cyc(1, 0, 0, 8'h00, "ar_clr");
    cyc(0, 1, 0, 8'h02, "ar_ld");
    for (int i = 1; i <= 7; i++) cyc(0, 0, 1, 8'h00, "ar_run");

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, d, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("[TB] FAIL timeout: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
